// File: rtl/heap_pkg.sv
// Shared opcodes, heap capacity and arbiter FSM encoding for the heap command path.
package heap_pkg;

  localparam int unsigned MAX_HEAP_SIZE = 32;
  localparam int unsigned OP_W          = 2;
  localparam int unsigned HP_OP_W       = 5;

  typedef enum logic [OP_W-1:0] {
    OP_INIT = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_SORT = 2'd3
  } heap_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ISSUE = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or above ptr, wrapping to index 0.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  int unsigned j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/heap_req_arbiter.sv
// Shares one heap between NUM_REQ requesters: round-robin accept, pre-check, one heap command,
// one response per request, plus a sticky check that the heap size moved as expected.
module heap_req_arbiter
  import heap_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = MAX_HEAP_SIZE,
  parameter int unsigned SIZE_W  = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [2*NUM_REQ-1:0]      req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      hp_enable,
  output logic [HP_OP_W-1:0]        hp_operation,
  output logic [DATA_W-1:0]         hp_value,
  input  logic [SIZE_W-1:0]         hp_size,
  input  logic [DATA_W-1:0]         hp_top,
  output logic                      busy,
  output logic                      size_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx, ptr_q, id_q;
  logic                any_req;
  heap_op_e            op_q;
  logic [DATA_W-1:0]   data_q, pop_val_q;
  logic [SIZE_W-1:0]   exp_size_q, post_size_c;
  logic                err_q, sorted_q, reject_c;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  // Accept is a same-cycle handshake with req_valid, so ready is decoded straight from IDLE.
  assign req_ready = (state_q == ST_IDLE && !reset) ? grant : '0;

  always_comb begin
    reject_c    = 1'b0;
    post_size_c = exp_size_q;
    case (op_q)
      OP_PUSH: begin
        reject_c    = (hp_size == SIZE_W'(DEPTH)) || sorted_q;
        post_size_c = exp_size_q + SIZE_W'(1);
      end
      OP_POP: begin
        reject_c    = (hp_size == '0) || sorted_q;
        post_size_c = exp_size_q - SIZE_W'(1);
      end
      OP_INIT: post_size_c = '0;
      default: post_size_c = exp_size_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_CHECK;
      ST_CHECK: state_d = reject_c ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request latches, rr pointer, sorted flag and post-command size check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      id_q       <= '0;
      op_q       <= OP_INIT;
      data_q     <= '0;
      pop_val_q  <= '0;
      exp_size_q <= '0;
      err_q      <= 1'b0;
      sorted_q   <= 1'b0;
      size_err   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (any_req) begin
          id_q   <= grant_idx;
          op_q   <= heap_op_e'(req_op[OP_W*grant_idx +: OP_W]);
          data_q <= req_data[DATA_W*grant_idx +: DATA_W];
          ptr_q  <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
        ST_CHECK: begin
          exp_size_q <= hp_size;
          pop_val_q  <= hp_top;
          err_q      <= reject_c;
        end
        ST_ISSUE: begin
          if (op_q == OP_INIT)      sorted_q <= 1'b0;
          else if (op_q == OP_SORT) sorted_q <= 1'b1;
        end
        ST_RESP: if (!err_q && hp_size != post_size_c) size_err <= 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs registered off the next state so each one lines up with its state's cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy         <= 1'b0;
      hp_enable    <= 1'b0;
      hp_operation <= '0;
      hp_value     <= '0;
      rsp_valid    <= '0;
      rsp_err      <= 1'b0;
      rsp_data     <= '0;
    end else begin
      busy         <= (state_d != ST_IDLE);
      hp_enable    <= (state_d == ST_ISSUE);
      hp_operation <= (state_d == ST_ISSUE) ? HP_OP_W'(op_q) : '0;
      hp_value     <= (state_d == ST_ISSUE && op_q == OP_PUSH) ? data_q : '0;
      rsp_valid    <= (state_d == ST_RESP) ? (NUM_REQ'(1) << id_q) : '0;
      rsp_err      <= (state_q == ST_CHECK && state_d == ST_RESP);
      rsp_data     <= (state_q == ST_ISSUE && op_q == OP_POP) ? pop_val_q : '0;
    end
  end

endmodule
